// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter: FSM state encoding,
// owner tag, counter width and block-offset mask.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_I_FILL  = 2'd1,
    ST_D_FILL  = 2'd2,
    ST_D_WRITE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int CNT_W           = 3;
  localparam int BLOCK_WORDS_DEF = 8;
  localparam int MEM_LAT_DEF     = 4;
  localparam int BLK_OFF_MASK    = 'hF;

  function automatic logic is_fill(input state_e s);
    return (s == ST_I_FILL) || (s == ST_D_FILL);
  endfunction

endpackage

// File: rtl/mem_arbiter_word_cnt.sv
// Word counter used for both the issue and return sides of a block fill.
// Synchronous clear wins over enable; tc flags the last word index.
module mem_word_cnt
  import mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == {CNT_W{1'b1}});

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between I-cache block fills and D-cache
// fills/writes, sequencing 8-word read bursts and routing returned words.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int MEM_LAT     = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_data_vld,
  output logic [2:0]        i_word_idx,
  output logic              i_done,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_data_vld,
  output logic [2:0]        d_word_idx,
  output logic              d_done,
  output logic [DATA_W-1:0] d_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvld
);

  if (BLOCK_WORDS != (1 << CNT_W) || MEM_LAT < 1 || ADDR_W <= 4) begin : g_bad_cfg
    $error("mem_arbiter: unsupported BLOCK_WORDS/MEM_LAT/ADDR_W combination");
  end

  function automatic logic [ADDR_W-1:0] blk_base(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(BLK_OFF_MASK);
  endfunction

  state_e            state_q;
  owner_e            last_owner_q;
  logic [ADDR_W-1:0] base_q;
  logic              issued_all_q;

  logic [CNT_W-1:0]  iss_idx;
  logic [CNT_W-1:0]  ret_idx;
  logic              iss_tc;
  logic              ret_tc;
  logic              in_fill;
  logic              issuing;
  logic              ret_en;
  logic              last_ret;
  logic              cnt_clr;

  assign in_fill  = is_fill(state_q);
  assign issuing  = in_fill && !issued_all_q;
  assign ret_en   = in_fill && mem_rvld;
  assign last_ret = ret_en && ret_tc;
  assign cnt_clr  = (state_q == ST_IDLE);

  mem_word_cnt u_iss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (issuing),
    .cnt_o (iss_idx),
    .tc_o  (iss_tc)
  );

  mem_word_cnt u_ret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (ret_en),
    .cnt_o (ret_idx),
    .tc_o  (ret_tc)
  );

  // On a tie the requester that did not own the last transaction wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWN_I;
      base_q       <= '0;
      issued_all_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          issued_all_q <= 1'b0;
          if (d_req && (!i_req || last_owner_q == OWN_I)) begin
            base_q  <= blk_base(d_addr);
            state_q <= d_wr ? ST_D_WRITE : ST_D_FILL;
          end else if (i_req) begin
            base_q  <= blk_base(i_addr);
            state_q <= ST_I_FILL;
          end
        end
        ST_I_FILL, ST_D_FILL: begin
          if (issuing && iss_tc) issued_all_q <= 1'b1;
          if (last_ret) begin
            state_q      <= ST_IDLE;
            last_owner_q <= (state_q == ST_I_FILL) ? OWN_I : OWN_D;
          end
        end
        ST_D_WRITE: begin
          state_q      <= ST_IDLE;
          last_owner_q <= OWN_D;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Low offset bits of base_q are zero, so the add never carries past the block.
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (issuing) begin
      mem_en   = 1'b1;
      mem_addr = base_q + ADDR_W'({iss_idx, 1'b0});
    end else if (state_q == ST_D_WRITE) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  assign i_grant    = (state_q == ST_I_FILL);
  assign d_grant    = (state_q == ST_D_FILL) || (state_q == ST_D_WRITE);

  assign i_data_vld = mem_rvld && (state_q == ST_I_FILL);
  assign d_data_vld = mem_rvld && (state_q == ST_D_FILL);
  assign i_word_idx = (state_q == ST_I_FILL) ? ret_idx : 3'd0;
  assign d_word_idx = (state_q == ST_D_FILL) ? ret_idx : 3'd0;
  assign i_done     = last_ret && (state_q == ST_I_FILL);
  assign d_done     = (last_ret && (state_q == ST_D_FILL)) || (state_q == ST_D_WRITE);

  assign i_data     = mem_rdata;
  assign d_data     = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model that
// returns 0xA000 + word-in-block for each read.
module tb_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req, d_wr;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_grant, i_data_vld, i_done;
  logic [2:0]    i_word_idx;
  logic [DW-1:0] i_data;
  logic          d_grant, d_data_vld, d_done;
  logic [2:0]    d_word_idx;
  logic [DW-1:0] d_data;
  logic          mem_en, mem_wr, mem_rvld;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          stray_rvld;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BLOCK_WORDS(8), .MEM_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_grant    (i_grant),
    .i_data_vld (i_data_vld),
    .i_word_idx (i_word_idx),
    .i_done     (i_done),
    .i_data     (i_data),
    .d_req      (d_req),
    .d_wr       (d_wr),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_grant    (d_grant),
    .d_data_vld (d_data_vld),
    .d_word_idx (d_word_idx),
    .d_done     (d_done),
    .d_data     (d_data),
    .mem_en     (mem_en),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvld   (mem_rvld)
  );

  // Memory model: read issued in cycle T shows mem_rvld in cycle T+LAT.
  logic          pv [LAT];
  logic [AW-1:0] pa [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= '0;
      end
    end else begin
      pv[0] <= mem_en && !mem_wr;
      pa[0] <= mem_addr;
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end

  assign mem_rvld  = pv[LAT-1] || stray_rvld;
  assign mem_rdata = 16'hA000 + {13'd0, pa[LAT-1][3:1]};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " i_grant"},    i_grant,    0);
    chk({tag, " d_grant"},    d_grant,    0);
    chk({tag, " i_data_vld"}, i_data_vld, 0);
    chk({tag, " d_data_vld"}, d_data_vld, 0);
    chk({tag, " i_word_idx"}, i_word_idx, 0);
    chk({tag, " d_word_idx"}, d_word_idx, 0);
    chk({tag, " i_done"},     i_done,     0);
    chk({tag, " d_done"},     d_done,     0);
    chk({tag, " mem_en"},     mem_en,     0);
    chk({tag, " mem_wr"},     mem_wr,     0);
    chk({tag, " mem_addr"},   mem_addr,   0);
    chk({tag, " mem_wdata"},  mem_wdata,  0);
  endtask

  // Caller has the request high in cycle T0; this walks T1..T13.
  task automatic run_fill(input bit dside, input logic [AW-1:0] addr, input int drop_t);
    logic [AW-1:0] base;
    logic [AW-1:0] ea;
    bit            iss;
    bit            ret;
    base = addr & 16'hFFF0;
    for (int t = 1; t <= 13; t++) begin
      step();
      iss = (t <= 8);
      ret = (t >= 5) && (t <= 12);
      ea  = iss ? base + 16'(2 * (t - 1)) : 16'h0;
      chk($sformatf("T%0d grant", t),       dside ? d_grant : i_grant, (t <= 12));
      chk($sformatf("T%0d other_grant", t), dside ? i_grant : d_grant, 0);
      chk($sformatf("T%0d mem_en", t),      mem_en, iss);
      chk($sformatf("T%0d mem_wr", t),      mem_wr, 0);
      chk($sformatf("T%0d mem_addr", t),    mem_addr, ea);
      chk($sformatf("T%0d data_vld", t),    dside ? d_data_vld : i_data_vld, ret);
      chk($sformatf("T%0d other_vld", t),   dside ? i_data_vld : d_data_vld, 0);
      if (ret) begin
        chk($sformatf("T%0d word_idx", t), dside ? d_word_idx : i_word_idx, t - 5);
        chk($sformatf("T%0d data", t),     dside ? d_data : i_data, 16'hA000 + 16'(t - 5));
      end
      chk($sformatf("T%0d done", t), dside ? d_done : i_done, (t == 12));
      if (t == drop_t || t == 12) begin
        if (dside) d_req = 1'b0;
        else       i_req = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    i_req      = 1'b0;
    d_req      = 1'b0;
    d_wr       = 1'b0;
    i_addr     = '0;
    d_addr     = '0;
    d_wdata    = '0;
    stray_rvld = 1'b0;
    step();
    step();
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    step();

    // Tie after reset: D wins, then I, then D again on the next tie.
    i_req  = 1'b1;
    i_addr = 16'h1234;
    d_req  = 1'b1;
    d_wr   = 1'b0;
    d_addr = 16'h0040;
    run_fill(1'b1, 16'h0040, 12);
    run_fill(1'b0, 16'h1234, 12);
    i_req  = 1'b1;
    d_req  = 1'b1;
    d_addr = 16'h0080;
    run_fill(1'b1, 16'h0080, 12);
    i_req  = 1'b0;
    step();

    // Single-word D write.
    d_req   = 1'b1;
    d_wr    = 1'b1;
    d_addr  = 16'h0102;
    d_wdata = 16'hBEEF;
    step();
    chk("wr T1 d_grant",   d_grant,   1);
    chk("wr T1 i_grant",   i_grant,   0);
    chk("wr T1 mem_en",    mem_en,    1);
    chk("wr T1 mem_wr",    mem_wr,    1);
    chk("wr T1 mem_addr",  mem_addr,  16'h0102);
    chk("wr T1 mem_wdata", mem_wdata, 16'hBEEF);
    chk("wr T1 d_done",    d_done,    1);
    chk("wr T1 d_vld",     d_data_vld, 0);
    d_req = 1'b0;
    d_wr  = 1'b0;
    step();
    chk_idle_outputs("wr T2");

    // Stray mem_rvld in IDLE must be ignored.
    stray_rvld = 1'b1;
    #1;
    chk("stray i_vld", i_data_vld, 0);
    chk("stray d_vld", d_data_vld, 0);
    step();
    stray_rvld = 1'b0;
    #1;
    chk_idle_outputs("after stray");

    // Block at top of address space.
    i_req  = 1'b1;
    i_addr = 16'hFFF6;
    run_fill(1'b0, 16'hFFF6, 12);

    // D fill with request dropped at T4.
    d_req  = 1'b1;
    d_wr   = 1'b0;
    d_addr = 16'h2000;
    run_fill(1'b1, 16'h2000, 4);

    // Reset at T5 of a D fill, then the fill restarts from word 0.
    d_req  = 1'b1;
    d_addr = 16'h0300;
    for (int t = 1; t <= 5; t++) step();
    chk("pre-rst T5 d_vld", d_data_vld, 1);
    chk("pre-rst T5 idx",   d_word_idx, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async rst");
    step();
    rst_n = 1'b1;
    run_fill(1'b1, 16'h0300, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
